full_adder_st: RTL and testbench

Registered ripple-carry adder built from structural full-adder cells. It adds two WIDTH-bit operands and a 1-bit carry-in, and registers the sum and carry-out on the clock. With the default WIDTH=1 it is a single clocked full adder. It is a leaf arithmetic block used wherever a small synchronous add with carry is needed.

---
 rtl/fa_pkg.sv | 10 +
 rtl/fa_cell.sv | 16 +
 rtl/full_adder_st.sv | 57 +++++
 tb/tb_full_adder_st.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fa_pkg.sv
// Shared constants and types for the registered ripple-carry adder.
// The result type is sized for the widest legal operand plus its carry-out.
package fa_pkg;

    localparam int unsigned FA_DEFAULT_WIDTH = 1;
    localparam int unsigned FA_MAX_WIDTH     = 64;

    typedef logic [FA_MAX_WIDTH:0] fa_result_t;

endpackage

// File: rtl/fa_cell.sv
// Gate-level single-bit full adder; one link of the ripple chain.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_p;

    assign w_p = x ^ y;
    assign s   = w_p ^ ci;
    assign co  = (x & y) | (ci & w_p);

endmodule

// File: rtl/full_adder_st.sv
// Registered ripple-carry adder: {Cout, sum} = a + b + c, one cycle of latency.
// Outputs hold their last result whenever in_valid is low.
module full_adder_st
    import fa_pkg::*;
#(
    parameter int unsigned WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             Cout,
    output logic             out_valid
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_valid;

    assign w_carry[0] = c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        fa_cell u_cell (
            .x  (a[i]),
            .y  (b[i]),
            .ci (w_carry[i]),
            .s  (w_sum[i]),
            .co (w_carry[i+1])
        );
    end

    // Result registers load only on valid, so unknown operands while idle never reach them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_carry[WIDTH];
            end
        end
    end

    assign sum       = r_sum;
    assign Cout      = r_cout;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_full_adder_st.sv
// Directed bench for full_adder_st at WIDTH=1 and WIDTH=8.
// Checks are packed as {out_valid, Cout, sum} against hand-computed values.
module tb_full_adder_st;
    import fa_pkg::*;

    logic       clk;
    logic       rst;

    logic       a1, b1, c1, v1;
    logic       s1, co1, vo1;

    logic [7:0] a8, b8;
    logic       c8, v8;
    logic [7:0] s8;
    logic       co8, vo8;

    int         n_tests;
    int         n_fail;

    logic [7:0] es;
    logic [7:0] ec;
    fa_result_t model;

    full_adder_st #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .a         (a1),
        .b         (b1),
        .c         (c1),
        .in_valid  (v1),
        .sum       (s1),
        .Cout      (co1),
        .out_valid (vo1)
    );

    full_adder_st #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .a         (a8),
        .b         (b8),
        .c         (c8),
        .in_valid  (v8),
        .sum       (s8),
        .Cout      (co8),
        .out_valid (vo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        es      = 8'b1001_0110;
        ec      = 8'b1110_1000;

        // Reset holds outputs at zero even with valid operands present.
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; v8 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("rst1_%0d", i), 10'({vo1, co1, s1}), 10'b000);
            chk($sformatf("rst8_%0d", i), {vo8, co8, s8}, 10'h000);
        end
        rst = 1'b0;
        v8  = 1'b0;

        // Truth table, one vector per cycle.
        for (int i = 0; i < 8; i++) begin
            {a1, b1, c1} = 3'(i);
            v1 = 1'b1;
            tick();
            chk($sformatf("tt%0d", i), 10'({vo1, co1, s1}), 10'({1'b1, ec[i], es[i]}));
        end

        // Hold while idle, including unknown operands.
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b1; v1 = 1'b1;
        tick();
        chk("hold_load", 10'({vo1, co1, s1}), 10'b110);
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b0;
        tick();
        chk("hold_111", 10'({vo1, co1, s1}), 10'b010);
        a1 = 1'bx; b1 = 1'bx; c1 = 1'bx;
        tick();
        chk("hold_x", 10'({vo1, co1, s1}), 10'b010);
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;

        // Full carry propagation.
        a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; v8 = 1'b1;
        tick();
        chk("ff_00_1", {vo8, co8, s8}, {1'b1, 1'b1, 8'h00});
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        tick();
        chk("ff_ff_1", {vo8, co8, s8}, {1'b1, 1'b1, 8'hFF});

        // Back-to-back stream.
        a8 = 8'h12; b8 = 8'h34; c8 = 1'b0;
        tick();
        chk("b2b_0", {vo8, co8, s8}, {1'b1, 1'b0, 8'h46});
        a8 = 8'h80; b8 = 8'h80; c8 = 1'b0;
        tick();
        chk("b2b_1", {vo8, co8, s8}, {1'b1, 1'b1, 8'h00});

        // A few more vectors against the wide arithmetic model.
        for (int i = 0; i < 4; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            c8 = 1'($urandom);
            model = fa_result_t'(a8) + fa_result_t'(b8) + fa_result_t'(c8);
            tick();
            chk($sformatf("rnd%0d", i), {vo8, co8, s8}, {1'b1, model[8:0]});
        end

        // Idle for one cycle: outputs hold, valid drops.
        v8 = 1'b0;
        a8 = 8'hxx; b8 = 8'hxx; c8 = 1'bx;
        tick();
        chk("hold8", {vo8, co8, s8}, {1'b0, model[8:0]});

        // Reset mid-stream: in-flight operands are discarded.
        a8 = 8'h55; b8 = 8'h11; c8 = 1'b0; v8 = 1'b1;
        tick();
        chk("pre_rst", {vo8, co8, s8}, {1'b1, 1'b0, 8'h66});
        a8 = 8'hF0; b8 = 8'h20; c8 = 1'b1; v8 = 1'b1; rst = 1'b1;
        tick();
        chk("mid_rst", {vo8, co8, s8}, 10'h000);
        rst = 1'b0; v8 = 1'b0;
        tick();
        chk("post_rst", {vo8, co8, s8}, 10'h000);
        a8 = 8'h01; b8 = 8'h02; c8 = 1'b1; v8 = 1'b1;
        tick();
        chk("first_after", {vo8, co8, s8}, {1'b1, 1'b0, 8'h04});
        v8 = 1'b0;
        tick();
        chk("first_after_idle", {vo8, co8, s8}, {1'b0, 1'b0, 8'h04});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
